// File: rtl/punc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// punc_mem_arbiter
//
// Shares the single-port PUnC memory between the core (fetch/load/store) and
// a debug/loader port. The memory macro has a synchronous read with one
// cycle of latency, so read data is routed back to whichever port issued
// the read on the previous cycle.
//
// Grant order (first match wins):
//   1. core lock held      -> core only, debug never granted
//   2. debug starved       -> debug (starve_cnt == STARVE_MAX and dbg_req)
//   3. core_req            -> core
//   4. dbg_req             -> debug
// With PUNC_ARB_RR_EN defined, rules 3/4 become round-robin on a tie using a
// last-winner register (reset value = debug, so core wins the first tie).
//
// Handshake: a requester holds req/we/addr/wdata stable until it sees its
// gnt. gnt is combinational and means the access is issued this cycle. For
// a read, rvalid pulses on the following cycle with rdata; writes give no
// rvalid.
//
// Ports:
//   clk, rst            clock (rising edge) / async active-low reset
//   core_*              core request, lock, grant and read return
//   dbg_*               debug request, grant and read return
//   mem_*               memory macro strobe, write enable, address, data
//
// Optional build macro: PUNC_ARB_RR_EN (round-robin tie break).
// ---------------------------------------------------------------------------
module punc_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic          core_lock,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic             lock;
  logic [CNT_W-1:0] starve_cnt;
  logic             rd_core;     // read issued by core last cycle
  logic             rd_dbg;      // read issued by debug last cycle
  logic             starved;

`ifdef PUNC_ARB_RR_EN
  logic             last_dbg;    // 1: debug won the most recent grant
`endif

  assign starved = (starve_cnt == STARVE_LIM) && dbg_req;

  // Grant decision. Reset is folded in so no access can leak to the memory
  // while rst is low, even though the grants are purely combinational.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!rst) begin
      core_gnt = 1'b0;
      dbg_gnt  = 1'b0;
    end else if (lock) begin
      core_gnt = core_req;
    end else if (starved) begin
      dbg_gnt = 1'b1;
    end else if (core_req && dbg_req) begin
`ifdef PUNC_ARB_RR_EN
      if (last_dbg) core_gnt = 1'b1;
      else          dbg_gnt  = 1'b1;
`else
      core_gnt = 1'b1;
`endif
    end else if (core_req) begin
      core_gnt = 1'b1;
    end else if (dbg_req) begin
      dbg_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock       <= 1'b0;
      starve_cnt <= '0;
      rd_core    <= 1'b0;
      rd_dbg     <= 1'b0;
    end else begin
      // Lock only changes on a core grant; idle cycles keep it.
      if (core_gnt) lock <= core_lock;

      if (!dbg_req || dbg_gnt)       starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;

      rd_core <= core_gnt && !core_we;
      rd_dbg  <= dbg_gnt  && !dbg_we;
    end
  end

`ifdef PUNC_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          last_dbg <= 1'b1;
    else if (core_gnt) last_dbg <= 1'b0;
    else if (dbg_gnt)  last_dbg <= 1'b1;
  end
`endif

  // Memory side: mux from the granted requester, zero when idle.
  always_comb begin
    mem_en    = core_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Read return: only the port that owns the pending read sees data.
  assign core_rvalid = rd_core;
  assign dbg_rvalid  = rd_dbg;
  assign core_rdata  = rd_core ? mem_rdata : '0;
  assign dbg_rdata   = rd_dbg  ? mem_rdata : '0;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_punc_mem_arbiter
//
// Directed bench for punc_mem_arbiter. A small synchronous-read memory model
// sits on the mem_* side. Inputs are driven 1 time unit after the rising
// edge; outputs are checked 3 units after the edge, mid-cycle.
// ---------------------------------------------------------------------------
module tb_punc_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          core_req, core_we, core_lock;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  punc_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_lock(core_lock),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory model: synchronous read, one cycle latency
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0] ^ {mem_addr[15:8]}] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0] ^ {mem_addr[15:8]}];
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic req, input logic we, input logic lk,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req = req; core_we = we; core_lock = lk; core_addr = a; core_wdata = d;
  endtask

  task automatic drive_dbg(input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    mem_rdata = '0;
    rst = 1'b0;
    drive_core(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    drive_dbg(1'b1, 1'b0, 16'h0011, 16'h0000);
    #3;
    // ---- reset state: requests present but nothing granted
    chk("rst_core_gnt",    core_gnt,    1'b0);
    chk("rst_dbg_gnt",     dbg_gnt,     1'b0);
    chk("rst_mem_en",      mem_en,      1'b0);
    chk("rst_mem_we",      mem_we,      1'b0);
    chk("rst_mem_addr",    mem_addr,    16'h0);
    chk("rst_mem_wdata",   mem_wdata,   16'h0);
    chk("rst_core_rvalid", core_rvalid, 1'b0);
    chk("rst_dbg_rvalid",  dbg_rvalid,  1'b0);
    chk("rst_core_rdata",  core_rdata,  16'h0);
    chk("rst_dbg_rdata",   dbg_rdata,   16'h0);
    drive_core(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    tick(); tick();
    rst = 1'b1;

    // ---- core write 0x1234 to 0x0010
    drive_core(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234);
    #2;
    chk("cw_gnt",   core_gnt,  1'b1);
    chk("cw_mem_we", mem_we,   1'b1);
    chk("cw_wdata", mem_wdata, 16'h1234);
    tick();
    // ---- core read of 0x0010
    drive_core(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
    #2;
    chk("cw_no_rvalid", core_rvalid, 1'b0);
    chk("cr_gnt",     core_gnt, 1'b1);
    chk("cr_mem_en",  mem_en,   1'b1);
    chk("cr_mem_we",  mem_we,   1'b0);
    chk("cr_mem_addr", mem_addr, 16'h0010);
    tick();
    drive_core(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    chk("cr_rvalid",     core_rvalid, 1'b1);
    chk("cr_rdata",      core_rdata,  16'h1234);
    chk("cr_dbg_rvalid", dbg_rvalid,  1'b0);
    chk("cr_dbg_rdata",  dbg_rdata,   16'h0);
    chk("cr_idle_en",    mem_en,      1'b0);
    tick();

    // ---- starvation: both request every cycle, debug forced in cycle 8
    drive_core(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
    drive_dbg(1'b1, 1'b1, 16'h0021, 16'h0);
    for (int c = 0; c < 12; c++) begin
      #2;
      chk($sformatf("starve_dbg_c%0d", c),  dbg_gnt,  (c == 8));
      chk($sformatf("starve_core_c%0d", c), core_gnt, (c != 8));
      tick();
    end
    drive_core(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    // ---- lock: debug blocked until the cycle after the unlocking write
    drive_core(1'b1, 1'b1, 1'b1, 16'h0040, 16'h1111);
    drive_dbg(1'b1, 1'b0, 16'h0010, 16'h0);
    #2;
    chk("lk_set_core", core_gnt, 1'b1);
    chk("lk_set_dbg",  dbg_gnt,  1'b0);
    tick();
    drive_core(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 7; i++) begin
      #2;
      chk($sformatf("lk_idle_a%0d", i), dbg_gnt, 1'b0);
      tick();
    end
    drive_core(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0);
    #2;
    chk("lk_rd_core", core_gnt, 1'b1);
    chk("lk_rd_dbg",  dbg_gnt,  1'b0);
    tick();
    drive_core(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    chk("lk_rd_rvalid", core_rvalid, 1'b1);
    chk("lk_rd_rdata",  core_rdata,  16'h1234);
    chk("lk_idle_b0",   dbg_gnt,     1'b0);
    tick();
    for (int i = 1; i < 3; i++) begin
      #2;
      chk($sformatf("lk_idle_b%0d", i), dbg_gnt, 1'b0);
      tick();
    end
    drive_core(1'b1, 1'b1, 1'b0, 16'h0040, 16'h5555);
    #2;
    chk("lk_unl_core", core_gnt, 1'b1);
    chk("lk_unl_dbg",  dbg_gnt,  1'b0);
    tick();
    drive_core(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    chk("lk_after_dbg",  dbg_gnt,  1'b1);
    chk("lk_after_addr", mem_addr, 16'h0010);
    chk("lk_after_we",   mem_we,   1'b0);
    tick();
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    chk("dr_rvalid",      dbg_rvalid,  1'b1);
    chk("dr_rdata",       dbg_rdata,   16'h1234);
    chk("dr_core_rvalid", core_rvalid, 1'b0);
    chk("dr_core_rdata",  core_rdata,  16'h0);
    tick();

    // ---- debug write 0xBEEF to 0x3000, then core reads it back
    drive_dbg(1'b1, 1'b1, 16'h3000, 16'hBEEF);
    #2;
    chk("dw_gnt",   dbg_gnt,   1'b1);
    chk("dw_en",    mem_en,    1'b1);
    chk("dw_we",    mem_we,    1'b1);
    chk("dw_addr",  mem_addr,  16'h3000);
    chk("dw_wdata", mem_wdata, 16'hBEEF);
    tick();
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    drive_core(1'b1, 1'b0, 1'b0, 16'h3000, 16'h0);
    #2;
    chk("dw_no_rvalid", dbg_rvalid, 1'b0);
    chk("rb_gnt",       core_gnt,   1'b1);
    tick();
    // back-to-back: core read 0x0040 right behind the previous read
    drive_core(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
    #2;
    chk("rb_rvalid", core_rvalid, 1'b1);
    chk("rb_rdata",  core_rdata,  16'hBEEF);
    tick();
    drive_core(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b1, 1'b0, 16'h3000, 16'h0);
    #2;
    chk("b2b_core_rdata", core_rdata, 16'h5555);
    chk("b2b_dbg_gnt",    dbg_gnt,    1'b1);
    tick();
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    chk("b2b_dbg_rdata",   dbg_rdata,   16'hBEEF);
    chk("b2b_core_rvalid", core_rvalid, 1'b0);
    tick();

    // ---- reset asserted while a core read is pending
    drive_core(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
    #2;
    chk("mr_gnt", core_gnt, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_gnt_rst",  core_gnt, 1'b0);
    chk("mr_en_rst",   mem_en,   1'b0);
    chk("mr_addr_rst", mem_addr, 16'h0);
    tick();
    chk("mr_rvalid_rst", core_rvalid, 1'b0);
    chk("mr_rdata_rst",  core_rdata,  16'h0);
    drive_core(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b1;
    #2;
    chk("mr_rvalid_after", core_rvalid, 1'b0);
    tick();

    // ---- tie behaviour straight after reset: both request writes
    drive_core(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0);
    drive_dbg(1'b1, 1'b1, 16'h0051, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #2;
`ifdef PUNC_ARB_RR_EN
      chk($sformatf("tie_core_%0d", i), core_gnt, (i % 2 == 0));
      chk($sformatf("tie_dbg_%0d", i),  dbg_gnt,  (i % 2 == 1));
`else
      chk($sformatf("tie_core_%0d", i), core_gnt, 1'b1);
      chk($sformatf("tie_dbg_%0d", i),  dbg_gnt,  1'b0);
`endif
      tick();
    end
    drive_core(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/punc_mem_arbiter.md
Name: punc_mem_arbiter

Overview:
Shares the single-port PUnC memory between two requesters: the core (control unit fetch, load and store traffic) and a debug/loader port.
- Core has fixed priority by default.
- Debug gets a starvation-bound guarantee.
- Core can lock the port across multi-access instructions (LDI/STI read-then-write) so debug cannot interleave.
- Sits between PUnCControl/datapath memory muxes and the memory macro (synchronous read, 1-cycle latency).

Parameters:
AW, 16, address width
DW, 16, data width
STARVE_MAX, 8, max consecutive cycles debug may wait before a forced grant (must be >=1)
CNT_W, 4, starvation counter width (must hold STARVE_MAX)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
core_req  input  1  core access request
core_we  input  1  core write (1) / read (0)
core_lock  input  1  keep port after this grant
core_addr  input  AW  core address
core_wdata  input  DW  core write data
core_gnt  output  1  core access issued this cycle
core_rvalid  output  1  core read data valid
core_rdata  output  DW  core read data
dbg_req  input  1  debug access request
dbg_we  input  1  debug write / read
dbg_addr  input  AW  debug address
dbg_wdata  input  DW  debug write data
dbg_gnt  output  1  debug access issued this cycle
dbg_rvalid  output  1  debug read data valid
dbg_rdata  output  DW  debug read data
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data (valid cycle after read issue)

Behaviour:
- Reset (rst=0, async): lock flag=0, starve_cnt=0, rd_owner=none. Outputs gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Requester holds req/we/addr/wdata stable until its gnt. gnt is combinational and same-cycle. At most one gnt per cycle.
- mem_en=core_gnt|dbg_gnt. mem_we/addr/wdata are muxed from the granted requester, else 0.
- Grant priority, evaluated in order:
  1. lock=1: core only. dbg_gnt=0 even if starved.
  2. starve_cnt==STARVE_MAX and dbg_req: debug.
  3. core_req: core.
  4. dbg_req: debug.
- lock: set on a cycle with core_gnt & core_lock. Cleared on a cycle with core_gnt & !core_lock. Otherwise held, including core_req=0 idle cycles.
- starve_cnt: cleared on dbg_gnt. Incremented (saturating at STARVE_MAX) when dbg_req & !dbg_gnt. Cleared when !dbg_req.
- Read return: a grant with we=0 sets rd_owner for the next cycle. Next cycle, that port's rvalid=1 and its rdata=mem_rdata; the other port's rdata=0. Back-to-back reads are supported every cycle, with no bubbles. Writes produce no rvalid.
- Reset mid-read: the pending rvalid is dropped and not replayed.
- Simultaneous core_req and dbg_req with no lock and no starvation: core wins, and debug counter increments.

Optional Feature:
PUNC_ARB_RR_EN:
- Defined: rule 3/4 fixed priority is replaced by round-robin. A last-winner register (reset = debug, so core wins the first tie) updates on every grant; on a tie, the non-last-winner is granted. Lock rule and starvation rule are unchanged.
- Undefined: fixed core priority as above, and no last-winner register.

Test Plan:
- Reset then core read addr 0x0010 (mem returns 0x1234) -> core_gnt=1 same cycle, mem_en=1, mem_we=0. Next cycle core_rvalid=1, core_rdata=0x1234, dbg_rvalid=0.
- core_req held high, dbg_req high from cycle 0, STARVE_MAX=8 -> dbg_gnt=1 exactly in cycle 8. starve_cnt back to 0, core granted cycles 0-7 and 9+.
- Core read with core_lock=1, then 3 idle cycles, then core write with core_lock=0, dbg_req high throughout and starve_cnt saturated -> dbg_gnt=0 until the cycle after the unlocking write.
- Debug write 0xBEEF to 0x3000, core idle -> mem_we=1, mem_addr=0x3000, mem_wdata=0xBEEF, no rvalid. Then core read of 0x3000 -> core_rdata=0xBEEF.
- Core read issued, rst pulsed low asynchronously before next edge -> core_rvalid stays 0, all outputs 0 during reset.
- PUNC_ARB_RR_EN defined, both requesting continuously -> grants alternate core, dbg, core, dbg from the first cycle after reset.
